fetch_unit: RTL

- Consumer side of the core's program counter. Holds the PC after reset, drives read requests to the synchronous instruction memory, and presents each returned instruction with its PC and a valid flag to decode.
- Accepts stalls from the pipeline and branch/jump redirects from execute.
- Sits between the PC/next-PC logic and the decode stage of the RISC-V core.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch front end; issues imem reads from the PC and presents inst/inst_pc/inst_valid to decode.
// Latency : 1 cycle from imem request (imem_en=1) to inst_valid/inst_pc for that address.
// Backpressure: stall holds the fetch (imem_en=0, PC and displayed response frozen); a redirect overrides stall.
//
// Ports:
//   clk, rst          core clock; asynchronous active-high reset
//   stall             pipeline stall from decode/execute
//   redirect_valid    take redirect_pc this cycle (branch/jump from execute)
//   redirect_pc       redirect target, low 2 bits ignored
//   imem_en/imem_addr synchronous imem read request
//   imem_dout         imem read data, valid one cycle after an enabled request
//   inst/inst_pc      fetched instruction and its PC
//   inst_valid        inst/inst_pc carry a live fetch
//
// Optional build macro FETCH_PERF_EN adds fetch_count and redirect_count outputs.

module fetch_unit #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_en,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_dout,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           redirect_count
`endif
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [PC_WIDTH-1:0]   target;
    logic                  fetch;

    // Redirect targets are forced word aligned; without a redirect the
    // request address is simply the sequential PC.
    always_comb begin
        target = pc_q;
        if (redirect_valid) begin
            target = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        fetch        = 1'b0;

        case (state_q)
            // First cycle out of reset always fetches; stall is not yet
            // meaningful because nothing has been presented to decode.
            BOOT: begin
                fetch   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    fetch = 1'b1;
                end else if (!stall) begin
                    fetch = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // A stalled cycle leaves everything untouched; with imem_en low the
        // BRAM keeps driving the same word, so inst stays stable too.
        if (fetch) begin
            pc_d         = target + PC_WIDTH'(4);
            resp_pc_d    = target;
            resp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // imem_en is gated by rst so the request drops the moment reset is
    // asserted, not at the next edge. When not fetching, target equals pc_q.
    assign imem_en    = fetch && !rst;
    assign imem_addr  = target;
    assign inst       = imem_dout;
    assign inst_pc    = resp_pc_q;
    assign inst_valid = resp_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (imem_en) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (redirect_valid && !rst) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule
